fetch_aligner: RTL and testbench

//  Realigns the 32-bit word-aligned instruction-fetch stream into whole RV32IC instructions.

---
 rtl/fetch_aligner_pkg.sv | 20 ++
 rtl/fetch_aligner.sv | 158 +++++++++++++++
 tb/tb_fetch_aligner.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_aligner_pkg.sv
// Shared definitions for the fetch aligner: state encoding and the
// instruction-length decode used to split RV32IC halves.
package fetch_aligner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_JOIN = 2'd3
  } state_e;

  // Low two bits of a 32-bit instruction parcel; anything else is 16-bit.
  localparam logic [1:0] INS_LEN32 = 2'b11;

  // True when the halfword starts a compressed (16-bit) instruction.
  function automatic logic is_comp(input logic [15:0] half);
    return half[1:0] != INS_LEN32;
  endfunction

endpackage

// File: rtl/fetch_aligner.sv
// Realigns the word-aligned fetch stream into whole RV32IC instructions,
// one per handshake, including 32-bit instructions straddling two words.
module fetch_aligner
  import fetch_aligner_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_data,
  input  logic [31:0] fetch_addr,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  output logic        ins_is_comp
);

  state_e      state_q, state_d;
  logic [31:0] wbuf_q, wbuf_d;          // current fetch word
  logic [31:0] buf_pc_q, buf_pc_d;      // word address of wbuf_q
  logic [15:0] save_q, save_d;          // low parcel of a straddling instruction
  logic [31:0] exp_addr_q, exp_addr_d;  // next word address we will accept
  logic        start_hi_q, start_hi_d;  // redirect landed on the high half

  logic comp_lo, comp_hi;
  logic fetch_fire, ins_fire, word_ok;

  // Only bits [31:1] of the redirect target are meaningful.
  logic unused_flush_bit0;
  assign unused_flush_bit0 = flush_pc[0];

  assign comp_lo = is_comp(wbuf_q[15:0]);
  assign comp_hi = is_comp(wbuf_q[31:16]);

  // Output decode from registered state; ready may bypass on a retiring fire.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    ins_valid   = 1'b0;
    fetch_ready = 1'b0;
    ins         = '0;
    ins_pc      = '0;
    ins_is_comp = 1'b0;
    unique case (state_q)
      ST_IDLE: fetch_ready = 1'b1;
      ST_LO: begin
        ins_valid = 1'b1;
        ins_pc    = buf_pc_q;
        if (comp_lo) begin
          ins         = {16'h0, wbuf_q[15:0]};
          ins_is_comp = 1'b1;
        end else begin
          ins         = wbuf_q;
          fetch_ready = ins_ready;  // last instruction of the word retires
        end
      end
      ST_HI: begin
        if (comp_hi) begin
          ins_valid   = 1'b1;
          ins         = {16'h0, wbuf_q[31:16]};
          ins_pc      = buf_pc_q + 32'd2;
          ins_is_comp = 1'b1;
          fetch_ready = ins_ready;
        end else begin
          fetch_ready = 1'b1;       // need the next word to finish the straddle
        end
      end
      ST_JOIN: begin
        ins_valid = 1'b1;
        ins       = {wbuf_q[15:0], save_q};
        ins_pc    = buf_pc_q - 32'd2;
      end
      default: ;
    endcase
  end

  assign fetch_fire = fetch_valid & fetch_ready;
  assign ins_fire   = ins_valid & ins_ready;
  assign word_ok    = fetch_fire & (fetch_addr == exp_addr_q);

  // Next-state and register-update logic; flush overrides everything.
  always_comb begin
    state_d    = state_q;
    wbuf_d     = wbuf_q;
    buf_pc_d   = buf_pc_q;
    save_d     = save_q;
    exp_addr_d = exp_addr_q;
    start_hi_d = start_hi_q;

    if (word_ok) begin
      wbuf_d     = fetch_data;
      buf_pc_d   = fetch_addr;
      exp_addr_d = exp_addr_q + 32'd4;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (word_ok) begin
          state_d    = start_hi_q ? ST_HI : ST_LO;
          start_hi_d = 1'b0;
        end
      end
      ST_LO: begin
        if (ins_fire) begin
          if (comp_lo) state_d = ST_HI;
          else         state_d = word_ok ? ST_LO : ST_IDLE;
        end
      end
      ST_HI: begin
        if (comp_hi) begin
          if (ins_fire) state_d = word_ok ? ST_LO : ST_IDLE;
        end else if (word_ok) begin
          save_d  = wbuf_q[31:16];
          state_d = ST_JOIN;
        end
      end
      ST_JOIN: begin
        if (ins_fire) state_d = ST_HI;
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      state_d    = ST_IDLE;
      wbuf_d     = wbuf_q;
      buf_pc_d   = buf_pc_q;
      save_d     = save_q;
      exp_addr_d = {flush_pc[31:2], 2'b00};
      start_hi_d = flush_pc[1];
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= ST_IDLE;
      wbuf_q     <= '0;
      buf_pc_q   <= '0;
      save_q     <= '0;
      exp_addr_q <= RESET_PC;
      start_hi_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wbuf_q     <= wbuf_d;
      buf_pc_q   <= buf_pc_d;
      save_q     <= save_d;
      exp_addr_q <= exp_addr_d;
      start_hi_q <= start_hi_d;
    end
  end

endmodule

// File: tb/tb_fetch_aligner.sv
// Directed self-checking bench for fetch_aligner.
module tb_fetch_aligner;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] flush_pc;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_data;
  logic [31:0] fetch_addr;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        ins_is_comp;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_data  (fetch_data),
    .fetch_addr  (fetch_addr),
    .ins_valid   (ins_valid),
    .ins_ready   (ins_ready),
    .ins         (ins),
    .ins_pc      (ins_pc),
    .ins_is_comp (ins_is_comp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    flush       = 1'b0;
    flush_pc    = '0;
    fetch_valid = 1'b0;
    fetch_data  = '0;
    fetch_addr  = '0;
    ins_ready   = 1'b1;
  endtask

  task automatic drive_word(input logic [31:0] a, input logic [31:0] d);
    fetch_valid = 1'b1;
    fetch_addr  = a;
    fetch_data  = d;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Check the full instruction output bundle at once.
  task automatic check_ins(input string tag, input logic [31:0] e_ins,
                           input logic [31:0] e_pc, input logic e_comp);
    check({tag, ".valid"}, {31'b0, ins_valid}, 32'd1);
    check({tag, ".ins"},   ins, e_ins);
    check({tag, ".pc"},    ins_pc, e_pc);
    check({tag, ".comp"},  {31'b0, ins_is_comp}, {31'b0, e_comp});
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();

    // Reset state.
    do_reset();
    settle();
    check("rst.valid", {31'b0, ins_valid}, 32'd0);
    check("rst.fready", {31'b0, fetch_ready}, 32'd1);
    check("rst.ins", ins, 32'd0);
    check("rst.pc", ins_pc, 32'd0);
    check("rst.comp", {31'b0, ins_is_comp}, 32'd0);

    // 1: two 32-bit instructions back to back.
    drive_word(32'h0, 32'h0000_0013);
    settle();
    check("t1.fready0", {31'b0, fetch_ready}, 32'd1);
    tick();
    drive_word(32'h4, 32'h0010_0093);
    settle();
    check_ins("t1.i0", 32'h0000_0013, 32'h0, 1'b0);
    check("t1.bypass", {31'b0, fetch_ready}, 32'd1);
    tick();
    fetch_valid = 1'b0;
    settle();
    check_ins("t1.i1", 32'h0010_0093, 32'h4, 1'b0);
    tick();
    settle();
    check("t1.drain", {31'b0, ins_valid}, 32'd0);

    // 2: two compressed instructions in one word.
    do_reset();
    drive_word(32'h0, 32'h4501_4501);
    tick();
    fetch_valid = 1'b0;
    settle();
    check_ins("t2.lo", 32'h0000_4501, 32'h0, 1'b1);
    check("t2.fready_lo", {31'b0, fetch_ready}, 32'd0);
    tick();
    settle();
    check_ins("t2.hi", 32'h0000_4501, 32'h2, 1'b1);
    check("t2.fready_hi", {31'b0, fetch_ready}, 32'd1);
    tick();
    settle();
    check("t2.drain", {31'b0, ins_valid}, 32'd0);

    // 3+4: straddle, with backpressure held in JOIN.
    do_reset();
    drive_word(32'h0, 32'h0013_4501);
    tick();
    drive_word(32'h4, 32'h4501_0000);
    settle();
    check_ins("t3.lo", 32'h0000_4501, 32'h0, 1'b1);
    check("t3.fready_lo", {31'b0, fetch_ready}, 32'd0);
    tick();
    settle();
    check("t3.hi_wait", {31'b0, ins_valid}, 32'd0);
    check("t3.hi_fready", {31'b0, fetch_ready}, 32'd1);
    tick();
    ins_ready = 1'b0;
    drive_word(32'h8, 32'h0000_0013);
    for (int i = 0; i < 5; i++) begin
      settle();
      check_ins($sformatf("t4.hold%0d", i), 32'h0000_0013, 32'h2, 1'b0);
      check($sformatf("t4.fready%0d", i), {31'b0, fetch_ready}, 32'd0);
      tick();
    end
    ins_ready = 1'b1;
    settle();
    check_ins("t3.join", 32'h0000_0013, 32'h2, 1'b0);
    tick();
    settle();
    check_ins("t3.hi6", 32'h0000_4501, 32'h6, 1'b1);
    check("t3.bypass", {31'b0, fetch_ready}, 32'd1);
    tick();
    fetch_valid = 1'b0;
    settle();
    check_ins("t4.nolost", 32'h0000_0013, 32'h8, 1'b0);
    tick();

    // 5: flush to 0x102 in LO, stale word dropped.
    do_reset();
    drive_word(32'h0, 32'h0000_0013);
    tick();
    fetch_valid = 1'b0;
    ins_ready   = 1'b0;
    flush       = 1'b1;
    flush_pc    = 32'h0000_0102;
    tick();
    flush     = 1'b0;
    ins_ready = 1'b1;
    drive_word(32'h4, 32'h1111_1111);
    settle();
    check("t5.flushed", {31'b0, ins_valid}, 32'd0);
    check("t5.fready", {31'b0, fetch_ready}, 32'd1);
    tick();
    drive_word(32'h100, 32'hABCD_0001);
    settle();
    check("t5.stale", {31'b0, ins_valid}, 32'd0);
    tick();
    fetch_valid = 1'b0;
    settle();
    check_ins("t5.target", 32'h0000_ABCD, 32'h102, 1'b1);
    tick();
    settle();
    check("t5.drain", {31'b0, ins_valid}, 32'd0);

    // 6a: reset while in JOIN.
    do_reset();
    drive_word(32'h0, 32'h0013_4501);
    tick();
    drive_word(32'h4, 32'h4501_0000);
    tick();
    tick();
    settle();
    check("t6.in_join", {31'b0, ins_valid}, 32'd1);
    fetch_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check("t6.rst_valid", {31'b0, ins_valid}, 32'd0);
    check("t6.rst_fready", {31'b0, fetch_ready}, 32'd1);
    drive_word(32'h0, 32'h0000_0013);
    tick();
    fetch_valid = 1'b0;
    settle();
    check_ins("t6.rst_pc", 32'h0000_0013, 32'h0, 1'b0);
    tick();

    // 6b: flush with simultaneous fetch and ins fires.
    drive_word(32'h4, 32'h0000_0013);
    tick();
    flush    = 1'b1;
    flush_pc = 32'h0000_0201;
    drive_word(32'h8, 32'h0000_0013);
    tick();
    flush       = 1'b0;
    fetch_valid = 1'b0;
    settle();
    check("t6.flush_valid", {31'b0, ins_valid}, 32'd0);
    drive_word(32'h8, 32'h0000_0013);
    tick();
    fetch_valid = 1'b0;
    settle();
    check("t6.stale8", {31'b0, ins_valid}, 32'd0);
    drive_word(32'h200, 32'h0000_0093);
    tick();
    fetch_valid = 1'b0;
    settle();
    check_ins("t6.target", 32'h0000_0093, 32'h200, 1'b0);
    tick();

    // PC wrap from the top of the address space.
    flush    = 1'b1;
    flush_pc = 32'hFFFF_FFFE;
    tick();
    flush = 1'b0;
    drive_word(32'hFFFF_FFFC, 32'h0001_0000);
    tick();
    drive_word(32'h0, 32'h0000_0013);
    settle();
    check_ins("wrap.hi", 32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
    check("wrap.bypass", {31'b0, fetch_ready}, 32'd1);
    tick();
    fetch_valid = 1'b0;
    settle();
    check_ins("wrap.zero", 32'h0000_0013, 32'h0, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
